// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI4-Stream byte sink that serializes each accepted byte as a
// UART frame (start, LSB-first data, optional parity, 1 or 2 stop bits).
// Ready is held low for the whole frame, so at most one byte is in flight.
module axis_uart_tx #(
  parameter int DATA_WDTH    = 8,
  parameter int CLKS_PER_BIT = 30,
  parameter int PARITY       = 0,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1
) (
  input  logic                 s_axis_clk,
  input  logic                 s_axis_aresetn,
  input  logic [DATA_WDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 uart_txd,
  output logic                 busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WDTH > 1) ? $clog2(DATA_WDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Illegal parameter sets are rejected at elaboration time.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $fatal(1, "axis_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "axis_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "axis_uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [BAUD_W-1:0]      r_baud;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_WDTH-1:0]   r_shift;
  logic [DATA_WDTH-1:0]   w_shift_next;
  logic                   r_par;
  logic                   r_txd;
  logic                   r_ready;
  logic                   r_busy;
  logic                   w_txd_next;
  logic                   w_ready_next;
  logic                   w_accept;
  logic                   w_baud_done;
  logic                   w_par_calc;

  // The handshake only completes in IDLE once ready has been raised.
  assign w_accept    = (r_state == ST_IDLE) && r_ready && s_axis_tvalid;
  assign w_baud_done = (r_baud == BAUD_LAST);
  // Even parity bit is the XOR of the data; odd parity is its complement.
  assign w_par_calc  = (PARITY == 2) ? (^s_axis_tdata) : (~^s_axis_tdata);

  // State register plus baud/bit counters, shift register and parity latch.
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_aresetn) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      if (w_accept) begin
        r_par <= w_par_calc;
      end
      if (r_state == ST_IDLE || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if (w_state_next != r_state) begin
        r_bit <= '0;
      end else if (w_baud_done) begin
        r_bit <= r_bit + 1'b1;
      end
    end
  end

  // Next-state logic: each non-idle state advances on a bit boundary.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_START;
      ST_START:  if (w_baud_done) w_state_next = ST_DATA;
      ST_DATA:   if (w_baud_done && r_bit == DATA_LAST)
                   w_state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_baud_done) w_state_next = ST_STOP;
      ST_STOP:   if (w_baud_done && r_bit == STOP_LAST) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Shift register load on accept, shift right at each data bit boundary.
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept) begin
      w_shift_next = s_axis_tdata;
    end else if (r_state == ST_DATA && w_baud_done) begin
      w_shift_next = r_shift >> 1;
    end
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    w_txd_next   = 1'b1;
    w_ready_next = (w_state_next == ST_IDLE);
    case (w_state_next)
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = w_shift_next[0];
      ST_PARITY: w_txd_next = r_par;
      default:   w_txd_next = 1'b1;
    endcase
  end

  // Output registers; reset forces the line idle-high with no low glitch.
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_aresetn) begin
      r_txd   <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_txd   <= w_txd_next;
      r_ready <= w_ready_next;
      r_busy  <= ~w_ready_next;
    end
  end

  assign uart_txd      = r_txd;
  assign s_axis_tready = r_ready;
  assign busy          = r_busy;

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: three serializers (8N1, 8E2, 8O1) at 4 clocks/bit, each
// driven by its own stimulus thread and checked every cycle against a frame
// model built from the byte sent.
module tb_axis_uart_tx;

  localparam int CPB = 4;
  localparam logic [7:0] SEQ [8] = '{8'hBA, 8'hDA, 8'hFA, 8'h55,
                                     8'h01, 8'h02, 8'h03, 8'h04};

  logic clk = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int PAR   = (gi == 0) ? 0 : ((gi == 1) ? 2 : 1);
    localparam int STP   = (gi == 1) ? 2 : 1;
    localparam int NBITS = 1 + 8 + ((PAR != 0) ? 1 : 0) + STP;
    localparam int FRM   = CPB * NBITS;

    logic       rstn;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tready;
    logic       txd;
    logic       busy;
    bit         done_q = 1'b0;

    axis_uart_tx #(
      .DATA_WDTH   (8),
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR),
      .STOP_BITS   (STP)
    ) u_dut (
      .s_axis_clk    (clk),
      .s_axis_aresetn(rstn),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .uart_txd      (txd),
      .busy          (busy)
    );

    // Expected line level for bit slot idx of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
      int ones;
      ones = $countones(b);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (PAR != 0 && idx == 9) begin
        // parity bit makes the total count of ones even (2) or odd (1)
        if (PAR == 2) return (ones % 2) == 1;
        return (ones % 2) == 0;
      end
      return 1'b1;
    endfunction

    task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        chk($sformatf("d%0d_idle_txd", gi), txd, 1);
        chk($sformatf("d%0d_idle_rdy", gi), tready, 1);
      end
    endtask

    // Called just after a negedge. Offers b, then checks every cycle of the frame.
    task automatic send(input logic [7:0] b, input bit noisy, input int abort_k, input bit b2b);
      int wait_n;
      wait_n = 0;
      while (tready !== 1'b1 && wait_n < 2 * FRM) begin
        @(negedge clk);
        wait_n++;
      end
      if (tready !== 1'b1) begin
        chk($sformatf("d%0d_ready_timeout", gi), tready, 1);
        return;
      end
      if (b2b) chk($sformatf("d%0d_b2b_gap", gi), wait_n, 0);
      tvalid = 1'b1;
      tdata  = b;
      for (int k = 0; k <= FRM; k++) begin
        @(negedge clk);
        if (k < FRM) begin
          chk($sformatf("d%0d_%02h_txd_k%0d", gi, b, k), txd, exp_bit(b, k / CPB));
          chk($sformatf("d%0d_%02h_rdy_k%0d", gi, b, k), tready, 0);
          chk($sformatf("d%0d_%02h_busy_k%0d", gi, b, k), busy, 1);
          if (noisy) tvalid = 1'($urandom);
          tdata = 8'($urandom);
        end else begin
          chk($sformatf("d%0d_%02h_end_txd", gi, b), txd, 1);
          chk($sformatf("d%0d_%02h_end_rdy", gi, b), tready, 1);
          chk($sformatf("d%0d_%02h_end_busy", gi, b), busy, 0);
        end
        if (k == abort_k) begin
          rstn   = 1'b0;
          tvalid = 1'b0;
          for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk($sformatf("d%0d_abort_txd", gi), txd, 1);
            chk($sformatf("d%0d_abort_rdy", gi), tready, 0);
            chk($sformatf("d%0d_abort_busy", gi), busy, 0);
          end
          rstn = 1'b1;
          @(negedge clk);
          chk($sformatf("d%0d_abort_rel_rdy", gi), tready, 1);
          return;
        end
      end
      tvalid = 1'b0;
    endtask

    initial begin
      rstn   = 1'b0;
      tvalid = 1'b0;
      tdata  = 8'h00;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk($sformatf("d%0d_rst_txd", gi), txd, 1);
        chk($sformatf("d%0d_rst_rdy", gi), tready, 0);
        chk($sformatf("d%0d_rst_busy", gi), busy, 0);
      end
      rstn = 1'b1;
      @(negedge clk);
      chk($sformatf("d%0d_first_rdy", gi), tready, 1);
      chk($sformatf("d%0d_first_busy", gi), busy, 0);
      chk($sformatf("d%0d_first_txd", gi), txd, 1);

      // FIFO-style back-to-back stream
      for (int i = 0; i < 8; i++) send(SEQ[i], 1'b0, -1, i > 0);

      // random bytes, random idle gaps, valid/data toggling mid-frame
      for (int i = 0; i < 6; i++) begin
        idle_chk(int'($urandom_range(0, 3)));
        send(8'($urandom), 1'b1, -1, 1'b0);
      end

      // reset during the 5th data bit of 0x55, then a clean 0xA5
      idle_chk(2);
      send(8'h55, 1'b0, 5 * CPB + CPB / 2, 1'b0);
      idle_chk(3);
      send(8'hA5, 1'b0, -1, 1'b0);
      idle_chk(2);
      done_q = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      if (g_dut[0].done_q && g_dut[1].done_q && g_dut[2].done_q) break;
      @(negedge clk);
    end
    chk("all_done", {29'd0, g_dut[2].done_q, g_dut[1].done_q, g_dut[0].done_q}, 32'h7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
